btn_conditioner: RTL

- Input-conditioning stage directly upstream of the two-player shooting core.
- Takes the five raw push-buttons (right0, left0, right1, left1, att) and produces clean, debounced signals for the core:
  - level outputs,
  - single-cycle press and release pulses,
  - an auto-repeat pulse for held movement buttons.
- All outputs are synchronous to the core clock, so the core never sees metastable inputs or contact bounce.

---
 rtl/btn_pkg.sv | 31 +++
 rtl/btn_channel.sv | 83 ++++++++
 rtl/btn_conditioner.sv | 35 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning stage: channel count,
// channel bit positions, and timing defaults for the board and for simulation.
package btn_pkg;

    localparam int unsigned N_BTN = 5;

    // Bit position of each button in btn_raw and in every output vector
    localparam int unsigned BTN_RIGHT0 = 0;
    localparam int unsigned BTN_LEFT0  = 1;
    localparam int unsigned BTN_RIGHT1 = 2;
    localparam int unsigned BTN_LEFT1  = 3;
    localparam int unsigned BTN_ATT    = 4;

    typedef logic [N_BTN-1:0] btn_vec_t;

    // 100 MHz board: 200 us debounce, 50 ms to first repeat, 25 ms repeat period
    localparam int unsigned DB_CYCLES_BOARD     = 20000;
    localparam int unsigned REPEAT_DELAY_BOARD  = 5000000;
    localparam int unsigned REPEAT_PERIOD_BOARD = 2500000;

    // Short values that keep simulations fast
    localparam int unsigned DB_CYCLES_SIM     = 4;
    localparam int unsigned REPEAT_DELAY_SIM  = 8;
    localparam int unsigned REPEAT_PERIOD_SIM = 3;

    // Larger of two cycle counts; sizes the shared repeat counter
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, counter-based debounce,
// registered press/release edge pulses and auto-repeat pulse generation.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_CYCLES_BOARD,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_BOARD,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_BOARD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep
);

    localparam int unsigned DCW  = $clog2(DB_CYCLES);
    localparam int unsigned RMAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic           s1;
    logic           s2;
    logic           stable;
    logic           stable_nxt;
    logic [DCW-1:0] dcnt;
    logic [DCW-1:0] dcnt_nxt;
    logic [RCW-1:0] rcnt;

    // Next debounced state: accept s2 only after DB_CYCLES consecutive disagreeing samples
    always_comb begin
        stable_nxt = stable;
        dcnt_nxt   = '0;
        if (s2 != stable) begin
            if (dcnt == DCW'(DB_CYCLES - 1)) begin
                stable_nxt = s2;
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state, edge pulses and repeat counter.
    // Edge and repeat decisions look at stable_nxt so the pulses line up with
    // the first cycle the new level is visible, and a release suppresses rep
    // in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            dcnt   <= '0;
            rcnt   <= '0;
            press  <= 1'b0;
            rel    <= 1'b0;
            rep    <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= stable_nxt;
            dcnt   <= dcnt_nxt;
            press  <= stable_nxt & ~stable;
            rel    <= ~stable_nxt & stable;
            if (!stable_nxt) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else if (!stable) begin
                rcnt <= RCW'(REPEAT_DELAY - 1);
                rep  <= 1'b1;
            end else if (rcnt == '0) begin
                rcnt <= RCW'(REPEAT_PERIOD - 1);
                rep  <= 1'b1;
            end else begin
                rcnt <= rcnt - 1'b1;
                rep  <= 1'b0;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Button conditioning top: fans each raw button bit through its own
// independent btn_channel and gathers the conditioned outputs.
module btn_conditioner #(
    parameter int unsigned N_BTN         = btn_pkg::N_BTN,
    parameter int unsigned DB_CYCLES     = btn_pkg::DB_CYCLES_BOARD,
    parameter int unsigned REPEAT_DELAY  = btn_pkg::REPEAT_DELAY_BOARD,
    parameter int unsigned REPEAT_PERIOD = btn_pkg::REPEAT_PERIOD_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rep
);

    // One conditioning channel per button bit
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i]),
            .rep  (btn_rep[i])
        );
    end

endmodule
